// File: rtl/pipe_flush_ctrl_pkg.sv
// rtl/pipe_flush_ctrl_pkg.sv - exception codes, default vectors and FSM encoding for pipe_flush_ctrl
package pipe_flush_ctrl_pkg;

   localparam logic [31:0] ZERO_WORD   = 32'h0000_0000;

   localparam logic [31:0] EXCT_NONE   = 32'h0000_0000;
   localparam logic [31:0] EXCT_INT    = 32'h0000_0001;
   localparam logic [31:0] EXCT_ADEL   = 32'h0000_0004;
   localparam logic [31:0] EXCT_ADES   = 32'h0000_0005;
   localparam logic [31:0] EXCT_SYS    = 32'h0000_0008;
   localparam logic [31:0] EXCT_BP     = 32'h0000_0009;
   localparam logic [31:0] EXCT_RI     = 32'h0000_000A;
   localparam logic [31:0] EXCT_OV     = 32'h0000_000C;
   localparam logic [31:0] EXCT_ERET   = 32'h0000_000E;

   localparam logic [31:0] DEF_EXC_VEC = 32'hBFC0_0380;
   localparam logic [31:0] DEF_BEV_VEC = 32'hBFC0_0380;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_FLUSH = 2'd1,
      ST_REDIR = 2'd2
   } state_t;

   function automatic logic exc_known(input logic [31:0] e);
      case (e)
         EXCT_INT, EXCT_ADEL, EXCT_ADES, EXCT_SYS,
         EXCT_BP, EXCT_RI, EXCT_OV, EXCT_ERET: exc_known = 1'b1;
         default:                              exc_known = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/pipe_flush_ctrl_if.sv
// rtl/pipe_flush_ctrl_if.sv - PC redirect handshake between the flush controller and IF
interface pipe_flush_ctrl_if;

   logic        redirect_valid;
   logic        redirect_ready;
   logic [31:0] new_pc;

   modport master (
      output redirect_valid,
      output new_pc,
      input  redirect_ready
   );

   modport slave (
      input  redirect_valid,
      input  new_pc,
      output redirect_ready
   );

endinterface

// File: rtl/pipe_flush_ctrl_stall_decode.sv
// rtl/pipe_flush_ctrl_stall_decode.sv - stall request priority encoder to hold thermometer
// The highest requesting stage holds itself and every stage (and the PC) upstream of it.
module pipe_flush_ctrl_stall_decode #(
   parameter int N_STAGES = 5
) (
   input  logic [N_STAGES-1:0] i_stallreq,
   output logic [N_STAGES:0]   o_stall
);

   logic w_acc;

   always_comb begin
      w_acc   = 1'b0;
      o_stall = '0;
      for (int i = N_STAGES - 1; i >= 0; i--) begin
         w_acc        = w_acc | i_stallreq[i];
         o_stall[i+1] = w_acc;
      end
      o_stall[0] = w_acc;
   end

endmodule

// File: rtl/pipe_flush_ctrl.sv
// rtl/pipe_flush_ctrl.sv - pipeline stall decode and exception/ERET flush + PC redirect sequencer
module pipe_flush_ctrl
   import pipe_flush_ctrl_pkg::*;
#(
   parameter int          N_STAGES     = 5,
   parameter int          FLUSH_CYCLES = 1,
   parameter logic [31:0] EXC_VEC      = DEF_EXC_VEC,
   parameter logic [31:0] BEV_VEC      = DEF_BEV_VEC,
   parameter int          CNT_W        = 32
) (
   input  logic                clk,
   input  logic                resetn,
   input  logic [N_STAGES-1:0] stallreq,
   input  logic [31:0]         exctype,
   input  logic [31:0]         cp0_epc,
   input  logic                bev,
   output logic [N_STAGES:0]   stall,
   output logic                flush,
   output logic                exc_unknown,
   output logic [CNT_W-1:0]    stall_cnt,
   pipe_flush_ctrl_if.master   redir
);

   localparam int FCNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
   localparam logic [FCNT_W-1:0] FCNT_INIT = FCNT_W'(FLUSH_CYCLES - 1);

   state_t              r_state;
   state_t              w_next;
   logic [FCNT_W-1:0]   r_fcnt;
   logic                r_done;
   logic                r_valid;
   logic [31:0]         r_new_pc;
   logic                r_exc_unknown;
   logic [CNT_W-1:0]    r_stall_cnt;

   logic [N_STAGES:0]   w_dec_stall;
   logic                w_exc_hit;
   logic                w_hs;
   logic                w_cnt_max;
   logic [31:0]         w_target;

   pipe_flush_ctrl_stall_decode #(
      .N_STAGES (N_STAGES)
   ) u_stall_decode (
      .i_stallreq (stallreq),
      .o_stall    (w_dec_stall)
   );

   assign w_hs      = r_valid & redir.redirect_ready;
   assign w_exc_hit = (r_state == ST_RUN) && exc_known(exctype);
   assign w_target  = (exctype == EXCT_ERET) ? cp0_epc : (bev ? BEV_VEC : EXC_VEC);
   assign w_cnt_max = &r_stall_cnt;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state <= ST_RUN;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      stall  = '0;
      flush  = 1'b0;
      case (r_state)
         ST_RUN: begin
            if (w_exc_hit) begin
               w_next = ST_FLUSH;
            end else begin
               stall = w_dec_stall;
            end
         end
         ST_FLUSH: begin
            flush = 1'b1;
            // A handshake already taken during the flush makes the REDIR wait pointless.
            if (r_fcnt == '0) begin
               w_next = (r_done || w_hs) ? ST_RUN : ST_REDIR;
            end
         end
         ST_REDIR: begin
            stall[0] = 1'b1;
            if (w_hs) begin
               w_next = ST_RUN;
            end
         end
         default: w_next = ST_RUN;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_fcnt        <= '0;
         r_done        <= 1'b0;
         r_valid       <= 1'b0;
         r_new_pc      <= ZERO_WORD;
         r_exc_unknown <= 1'b0;
         r_stall_cnt   <= '0;
      end else begin
         r_exc_unknown <= (r_state == ST_RUN) && (exctype != EXCT_NONE) && !exc_known(exctype);
         if (w_exc_hit) begin
            r_fcnt   <= FCNT_INIT;
            r_done   <= 1'b0;
            r_valid  <= 1'b1;
            r_new_pc <= w_target;
         end else begin
            if ((r_state == ST_FLUSH) && (r_fcnt != '0)) begin
               r_fcnt <= r_fcnt - FCNT_W'(1);
            end
            if (w_hs) begin
               r_valid  <= 1'b0;
               r_new_pc <= ZERO_WORD;
               r_done   <= 1'b1;
            end
         end
         if ((r_state == ST_RUN) && stall[0] && !w_cnt_max) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
         end
      end
   end

   assign redir.redirect_valid = r_valid;
   assign redir.new_pc         = r_new_pc;
   assign exc_unknown          = r_exc_unknown;
   assign stall_cnt            = r_stall_cnt;

endmodule

// File: tb/tb_pipe_flush_ctrl.sv
// tb/tb_pipe_flush_ctrl.sv - randomized + directed bench for pipe_flush_ctrl against a behavioural model
module tb_pipe_flush_ctrl;
   import pipe_flush_ctrl_pkg::*;

   localparam logic [31:0] T_EXC = 32'hBFC0_0380;
   localparam logic [31:0] T_BEV = 32'hBFC0_0200;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        resetn;
   logic [4:0]  stallreq;
   logic [31:0] exctype;
   logic [31:0] cp0_epc;
   logic        bev;
   logic        ready;

   logic [5:0]  stall_a, stall_b;
   logic        flush_a, flush_b;
   logic        unk_a, unk_b;
   logic [3:0]  cnt_a, cnt_b;

   pipe_flush_ctrl_if if_a ();
   pipe_flush_ctrl_if if_b ();
   assign if_a.redirect_ready = ready;
   assign if_b.redirect_ready = ready;

   pipe_flush_ctrl #(.N_STAGES(5), .FLUSH_CYCLES(1), .EXC_VEC(T_EXC), .BEV_VEC(T_BEV), .CNT_W(4)) u_dut_a (
      .clk(clk), .resetn(resetn), .stallreq(stallreq), .exctype(exctype), .cp0_epc(cp0_epc),
      .bev(bev), .stall(stall_a), .flush(flush_a), .exc_unknown(unk_a), .stall_cnt(cnt_a), .redir(if_a)
   );

   pipe_flush_ctrl #(.N_STAGES(5), .FLUSH_CYCLES(3), .EXC_VEC(T_EXC), .BEV_VEC(T_BEV), .CNT_W(4)) u_dut_b (
      .clk(clk), .resetn(resetn), .stallreq(stallreq), .exctype(exctype), .cp0_epc(cp0_epc),
      .bev(bev), .stall(stall_b), .flush(flush_b), .exc_unknown(unk_b), .stall_cnt(cnt_b), .redir(if_b)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", tag, obs, exp);
      end
   endtask

   // Model: remaining flush cycles and an outstanding redirect fully describe the controller.
   int          m_fl  [2];
   bit          m_v   [2];
   logic [31:0] m_pc  [2];
   bit          m_unk [2];
   int          m_cnt [2];

   function automatic int flush_len(input int k);
      return (k == 0) ? 1 : 3;
   endfunction

   function automatic bit is_known(input logic [31:0] e);
      return e inside {EXCT_INT, EXCT_ADEL, EXCT_ADES, EXCT_SYS, EXCT_BP, EXCT_RI, EXCT_OV, EXCT_ERET};
   endfunction

   function automatic logic [5:0] thermo(input logic [4:0] sr);
      int h;
      h = -1;
      for (int i = 0; i < 5; i++) if (sr[i]) h = i;
      if (h < 0) return 6'd0;
      return 6'((1 << (h + 2)) - 1);
   endfunction

   function automatic logic [5:0] exp_stall(input int k);
      if (m_fl[k] > 0) return 6'd0;
      if (m_v[k]) return 6'b000001;
      if (is_known(exctype)) return 6'd0;
      return thermo(stallreq);
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_fl[k] = 0; m_v[k] = 0; m_pc[k] = '0; m_unk[k] = 0; m_cnt[k] = 0;
      end
   endtask

   task automatic model_tick();
      for (int k = 0; k < 2; k++) begin
         bit run, hs;
         run      = (m_fl[k] == 0) && !m_v[k];
         hs       = m_v[k] && ready;
         m_unk[k] = run && (exctype != 0) && !is_known(exctype);
         if (run && is_known(exctype)) begin
            m_fl[k] = flush_len(k);
            m_v[k]  = 1;
            m_pc[k] = (exctype == EXCT_ERET) ? cp0_epc : (bev ? T_BEV : T_EXC);
         end else if (run) begin
            if ((stallreq != 0) && (m_cnt[k] < 15)) m_cnt[k]++;
         end else begin
            if (hs) begin
               m_v[k]  = 0;
               m_pc[k] = '0;
            end
            if (m_fl[k] > 0) m_fl[k]--;
         end
      end
   endtask

   task automatic cmp_one(input string p, input int k, input logic [5:0] st, input logic fl,
                          input logic v, input logic [31:0] pc, input logic u, input logic [3:0] c);
      check_val({p, " stall"},     32'(st), 32'(exp_stall(k)));
      check_val({p, " flush"},     32'(fl), 32'(m_fl[k] > 0));
      check_val({p, " valid"},     32'(v),  32'(m_v[k]));
      check_val({p, " new_pc"},    pc,      m_pc[k]);
      check_val({p, " unknown"},   32'(u),  32'(m_unk[k]));
      check_val({p, " stall_cnt"}, 32'(c),  32'(m_cnt[k]));
   endtask

   task automatic compare_all();
      cmp_one("a", 0, stall_a, flush_a, if_a.redirect_valid, if_a.new_pc, unk_a, cnt_a);
      cmp_one("b", 1, stall_b, flush_b, if_b.redirect_valid, if_b.new_pc, unk_b, cnt_b);
   endtask

   task automatic drive_cmp(input logic [4:0] sr, input logic [31:0] ex, input logic [31:0] epc,
                            input logic b, input logic rdy);
      @(negedge clk);
      stallreq = sr; exctype = ex; cp0_epc = epc; bev = b; ready = rdy;
      #1;
      compare_all();
   endtask

   task automatic tick();
      @(posedge clk);
      model_tick();
   endtask

   task automatic step(input logic [4:0] sr, input logic [31:0] ex, input logic [31:0] epc,
                       input logic b, input logic rdy);
      drive_cmp(sr, ex, epc, b, rdy);
      tick();
   endtask

   logic [31:0] codes [8] = '{EXCT_INT, EXCT_ADEL, EXCT_ADES, EXCT_SYS, EXCT_BP, EXCT_RI, EXCT_OV, EXCT_ERET};

   initial begin
      resetn = 1'b0; stallreq = '0; exctype = '0; cp0_epc = '0; bev = 1'b0; ready = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk); #1;
      compare_all();
      resetn = 1'b1;

      // stall thermometer and saturating counter
      drive_cmp(5'b00100, '0, '0, 0, 0);
      check_val("t1 stall 00100", 32'(stall_a), 32'(6'b001111));
      tick();
      drive_cmp(5'b10001, '0, '0, 0, 0);
      check_val("t1 stall 10001", 32'(stall_b), 32'(6'b111111));
      tick();
      repeat (16) step(5'b10001, '0, '0, 0, 0);
      drive_cmp('0, '0, '0, 0, 0);
      check_val("t1 cnt saturated", 32'(cnt_a), 32'd15);
      tick();

      // SYS exception, immediate handshake
      drive_cmp(5'b00011, EXCT_SYS, '0, 0, 1);
      check_val("t2 stall on exc", 32'(stall_a), 32'd0);
      tick();
      drive_cmp('0, '0, '0, 0, 1);
      check_val("t2 flush", 32'(flush_a), 32'd1);
      check_val("t2 valid", 32'(if_a.redirect_valid), 32'd1);
      check_val("t2 new_pc", if_a.new_pc, T_EXC);
      tick();
      drive_cmp('0, '0, '0, 0, 1);
      check_val("t2 flush done", 32'(flush_a), 32'd0);
      tick();
      repeat (4) step('0, '0, '0, 0, 1);

      // ERET with IF back-pressure
      step('0, EXCT_ERET, 32'h8000_1234, 0, 0);
      for (int i = 0; i < 5; i++) begin
         drive_cmp('0, '0, '0, 0, 0);
         check_val("t3 epc held", if_b.new_pc, 32'h8000_1234);
         tick();
      end
      drive_cmp('0, '0, '0, 0, 1);
      check_val("t3 redir stall", 32'(stall_b), 32'(6'b000001));
      tick();
      repeat (3) step('0, '0, '0, 0, 1);

      // unknown exception code
      drive_cmp(5'b00010, 32'h0000_00FF, '0, 0, 0);
      check_val("t4 stall", 32'(stall_a), 32'(6'b000111));
      tick();
      drive_cmp('0, '0, '0, 0, 0);
      check_val("t4 unknown pulse", 32'(unk_a), 32'd1);
      tick();
      step('0, '0, '0, 0, 0);

      // exception during FLUSH is dropped
      step('0, EXCT_SYS, '0, 0, 0);
      drive_cmp(5'b11111, EXCT_OV, 32'h1111_2222, 1, 0);
      check_val("t5 stall", 32'(stall_b), 32'd0);
      check_val("t5 target", if_b.new_pc, T_EXC);
      tick();
      repeat (4) step('0, '0, '0, 0, 1);

      // async reset in REDIR
      step('0, EXCT_SYS, '0, 1, 0);
      repeat (4) step('0, '0, '0, 0, 0);
      @(negedge clk);
      resetn = 1'b0;
      #1;
      model_reset();
      compare_all();
      @(posedge clk);
      @(negedge clk);
      resetn = 1'b1;
      repeat (3) step('0, '0, '0, 0, 1);

      // random traffic
      for (int n = 0; n < 400; n++) begin
         int r;
         logic [31:0] ex;
         r = int'($urandom_range(0, 99));
         if (r < 70)      ex = '0;
         else if (r < 85) ex = codes[$urandom_range(0, 7)];
         else if (r < 93) ex = 32'h0000_00FF;
         else             ex = $urandom();
         step(5'($urandom()), ex, $urandom(), 1'($urandom()), 1'($urandom()));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
